// File: rtl/dich_univ.sv
// dich_univ: parametrised universal shift register (shift L/R, rotate L/R,
//            parallel load, clear) with serial-out bit and saturating fill count.
// Latency: one clk from the sampling edge to LED/SOUT/CNT; FULL follows CNT
//          combinationally.
// Backpressure: none; en=0 freezes all state, so en acts as the stall.
//
// Ports:
//   clk   - system clock, rising edge
//   rs    - asynchronous active-high reset
//   en    - clock enable; 0 holds LED, SOUT and CNT
//   mode  - operation select (HOLD/SHL/SHR/ROL/ROR/LOAD/CLR, 7 = HOLD)
//   DIN   - serial data in for the shift modes
//   PIN   - parallel load data
//   LED   - register contents
//   SOUT  - last bit shifted or rotated out
//   CNT   - number of valid shifted-in bits, saturating at WIDTH
//   FULL  - CNT == WIDTH
module dich_univ #(
    parameter int               WIDTH   = 8,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic                         clk,
    input  logic                         rs,
    input  logic                         en,
    input  logic [2:0]                   mode,
    input  logic                         DIN,
    input  logic [WIDTH-1:0]             PIN,
    output logic [WIDTH-1:0]             LED,
    output logic                         SOUT,
    output logic [$clog2(WIDTH+1)-1:0]   CNT,
    output logic                         FULL
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(WIDTH);

    typedef enum logic [2:0] {
        MODE_HOLD = 3'd0,
        MODE_SHL  = 3'd1,
        MODE_SHR  = 3'd2,
        MODE_ROL  = 3'd3,
        MODE_ROR  = 3'd4,
        MODE_LOAD = 3'd5,
        MODE_CLR  = 3'd6,
        MODE_RSVD = 3'd7
    } mode_e;

    logic [WIDTH-1:0] led_q,  led_d;
    logic             sout_q, sout_d;
    logic [CW-1:0]    cnt_q,  cnt_d;
    logic [CW-1:0]    cnt_inc;
    mode_e            mode_s;

    assign mode_s = mode_e'(mode);

    // Shifts count fresh bits in but must never wrap past WIDTH.
    assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CW'(1);

    always_comb begin
        led_d  = led_q;
        sout_d = sout_q;
        cnt_d  = cnt_q;
        if (en) begin
            unique case (mode_s)
                MODE_SHL: begin
                    led_d  = {led_q[WIDTH-2:0], DIN};
                    sout_d = led_q[WIDTH-1];
                    cnt_d  = cnt_inc;
                end
                MODE_SHR: begin
                    led_d  = {DIN, led_q[WIDTH-1:1]};
                    sout_d = led_q[0];
                    cnt_d  = cnt_inc;
                end
                MODE_ROL: begin
                    led_d  = {led_q[WIDTH-2:0], led_q[WIDTH-1]};
                    sout_d = led_q[WIDTH-1];
                end
                MODE_ROR: begin
                    led_d  = {led_q[0], led_q[WIDTH-1:1]};
                    sout_d = led_q[0];
                end
                MODE_LOAD: begin
                    // SOUT deliberately untouched: a load shifts nothing out.
                    led_d = PIN;
                    cnt_d = CNT_MAX;
                end
                MODE_CLR: begin
                    led_d  = '0;
                    sout_d = 1'b0;
                    cnt_d  = '0;
                end
                MODE_HOLD, MODE_RSVD: begin
                    led_d  = led_q;
                    sout_d = sout_q;
                    cnt_d  = cnt_q;
                end
                default: begin
                    led_d  = led_q;
                    sout_d = sout_q;
                    cnt_d  = cnt_q;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rs) begin
        if (rs) begin
            led_q  <= RST_VAL;
            sout_q <= 1'b0;
            cnt_q  <= '0;
        end else begin
            led_q  <= led_d;
            sout_q <= sout_d;
            cnt_q  <= cnt_d;
        end
    end

    assign LED  = led_q;
    assign SOUT = sout_q;
    assign CNT  = cnt_q;
    assign FULL = (cnt_q == CNT_MAX);

endmodule
